wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the main-pipe writeback with a queue of
// long-latency results onto one registered register-file write port, and
// provides operand bypass from that port plus a stall for queued producers.
module wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pipe_valid,
   input  logic                       pipe_wr,
   input  logic [4:0]                 pipe_dst,
   input  logic [31:0]                pipe_result,
   input  logic                       slow_valid,
   output logic                       slow_ready,
   input  logic [4:0]                 slow_dst,
   input  logic [31:0]                slow_result,
   output logic [4:0]                 WB_Dst,
   output logic [31:0]                WB_Result,
   output logic                       RFWr,
   input  logic [4:0]                 ID_rs,
   input  logic [4:0]                 ID_rt,
   input  logic [31:0]                ID_BusA,
   input  logic [31:0]                ID_BusB,
   output logic [31:0]                ID_FwdA,
   output logic [31:0]                ID_FwdB,
   output logic                       ID_Stall,
   output logic [$clog2(DEPTH):0]     q_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // queue storage: live bits are control (reset), dst/data are payload
   logic [DEPTH-1:0]  q_live;
   logic [4:0]        q_dst  [DEPTH];
   logic [31:0]       q_data [DEPTH];
   logic [AW-1:0]     rd_ptr, wr_ptr;

   // registered write port
   logic              out_valid;
   logic [4:0]        out_dst;
   logic [31:0]       out_data;

   logic              pipe_we, slow_acc, push, push_live, head_valid, head_live, pop;

   assign pipe_we    = pipe_valid & pipe_wr & (pipe_dst != 5'd0);
   assign slow_ready = (q_count < FULL);
   assign slow_acc   = slow_valid & slow_ready;
   // r0 beats are acknowledged but never occupy a slot
   assign push       = slow_acc & (slow_dst != 5'd0);
   // a same-cycle pipe write to the same register is younger: beat is born dead
   assign push_live  = ~(pipe_we & (pipe_dst == slow_dst));
   assign head_valid = (q_count != '0);
   assign head_live  = head_valid & q_live[rd_ptr];
   // dead heads always drain; live heads drain only when the pipe is not writing
   assign pop        = head_valid & (~q_live[rd_ptr] | ~pipe_we);

   assign RFWr       = out_valid;
   assign WB_Dst     = out_dst;
   assign WB_Result  = out_data;

   // queue control: pointers, occupancy, live bits and squash by younger pipe writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         q_count <= '0;
         q_live  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (pipe_we && q_dst[i] == pipe_dst) q_live[i] <= 1'b0;
         end
         if (pop) begin
            q_live[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + 1'b1;
         end
         if (push) begin
            q_live[wr_ptr] <= push_live;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   q_count <= q_count + 1'b1;
            2'b01:   q_count <= q_count - 1'b1;
            default: q_count <= q_count;
         endcase
      end
   end

   // queue payload capture on push
   always_ff @(posedge clk) begin
      if (push) begin
         q_dst[wr_ptr]  <= slow_dst;
         q_data[wr_ptr] <= slow_result;
      end
   end

   // output stage: pipe has priority, else a live queue head, else idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_dst   <= '0;
         out_data  <= '0;
      end else if (pipe_we) begin
         out_valid <= 1'b1;
         out_dst   <= pipe_dst;
         out_data  <= pipe_result;
      end else if (head_live) begin
         out_valid <= 1'b1;
         out_dst   <= q_dst[rd_ptr];
         out_data  <= q_data[rd_ptr];
      end else begin
         out_valid <= 1'b0;
      end
   end

   // bypass from the registered write port only
   always_comb begin
      ID_FwdA = ID_BusA;
      ID_FwdB = ID_BusB;
      if (out_valid && out_dst == ID_rs && ID_rs != 5'd0) ID_FwdA = out_data;
      if (out_valid && out_dst == ID_rt && ID_rt != 5'd0) ID_FwdB = out_data;
   end

   // stall while a pending slow producer (queued live or arriving now) targets an operand
   always_comb begin
      ID_Stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (q_live[i] && ((ID_rs != 5'd0 && q_dst[i] == ID_rs) ||
                           (ID_rt != 5'd0 && q_dst[i] == ID_rt)))
            ID_Stall = 1'b1;
      end
      if (push && ((ID_rs != 5'd0 && slow_dst == ID_rs) ||
                   (ID_rt != 5'd0 && slow_dst == ID_rt)))
         ID_Stall = 1'b1;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=4): reset, bypass, queue ordering,
// backpressure, squash of stale slow results, r0 handling, mid-run reset.
module tb_wb_arbiter;

   logic        clk, rst;
   logic        pipe_valid, pipe_wr, slow_valid, slow_ready;
   logic [4:0]  pipe_dst, slow_dst, WB_Dst, ID_rs, ID_rt;
   logic [31:0] pipe_result, slow_result, WB_Result, ID_BusA, ID_BusB, ID_FwdA, ID_FwdB;
   logic        RFWr, ID_Stall;
   logic [2:0]  q_count;

   int total = 0;
   int bad   = 0;

   wb_arbiter #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .pipe_valid(pipe_valid), .pipe_wr(pipe_wr), .pipe_dst(pipe_dst), .pipe_result(pipe_result),
      .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_dst(slow_dst), .slow_result(slow_result),
      .WB_Dst(WB_Dst), .WB_Result(WB_Result), .RFWr(RFWr),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_BusA(ID_BusA), .ID_BusB(ID_BusB),
      .ID_FwdA(ID_FwdA), .ID_FwdB(ID_FwdB), .ID_Stall(ID_Stall), .q_count(q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic v, input logic [4:0] d, input logic [31:0] r);
      pipe_valid = v; pipe_wr = v; pipe_dst = d; pipe_result = r;
   endtask

   task automatic slow(input logic v, input logic [4:0] d, input logic [31:0] r);
      slow_valid = v; slow_dst = d; slow_result = r;
   endtask

   // the write port must never target r0
   always @(negedge clk) begin
      if (rst === 1'b1) chk("no_r0_write", {31'd0, RFWr & (WB_Dst == 5'd0)}, 32'd0);
   end

   initial begin
      pipe(0, 0, 0); slow(0, 0, 0);
      ID_rs = 0; ID_rt = 0; ID_BusA = 32'hDEAD_000A; ID_BusB = 32'hDEAD_000B;
      rst = 1'b0;
      #12;
      chk("rst_rfwr",  RFWr, 0);
      chk("rst_dst",   WB_Dst, 0);
      chk("rst_res",   WB_Result, 0);
      chk("rst_count", q_count, 0);
      rst = 1'b1;
      tick();
      chk("rst_ready", slow_ready, 1);

      // pipe write r5 then bypass
      pipe(1, 5, 32'h1234);
      tick();
      pipe(0, 0, 0);
      chk("p_rfwr", RFWr, 1);
      chk("p_dst",  WB_Dst, 5);
      chk("p_res",  WB_Result, 32'h1234);
      ID_rs = 5; ID_rt = 0;
      #1;
      chk("fwdA",  ID_FwdA, 32'h1234);
      chk("fwdB_raw", ID_FwdB, 32'hDEAD_000B);
      tick();
      chk("p_idle", RFWr, 0);
      chk("fwdA_raw", ID_FwdA, 32'hDEAD_000A);
      ID_rs = 0;

      // slow r7 waits behind three pipe writes to r3
      ID_rt = 7;
      slow(1, 7, 32'hAA);
      for (int k = 0; k < 3; k++) begin
         pipe(1, 3, 32'h300 + k);
         #1;
         chk("q_stall", ID_Stall, 1);
         tick();
         slow(0, 0, 0);
         chk("q_pdst", WB_Dst, 3);
         chk("q_pres", WB_Result, 32'h300 + k);
         chk("q_cnt1", q_count, 1);
      end
      pipe(0, 0, 0);
      #1;
      chk("q_stall_hold", ID_Stall, 1);
      tick();
      chk("q_rfwr", RFWr, 1);
      chk("q_dst",  WB_Dst, 7);
      chk("q_res",  WB_Result, 32'hAA);
      chk("q_cnt0", q_count, 0);
      chk("q_unstall", ID_Stall, 0);
      ID_rt = 0;

      // fill the queue with the pipe busy, then backpressure and drain
      for (int k = 0; k < 4; k++) begin
         pipe(1, 1, 32'h1);
         slow(1, 5'(10 + k), 32'h100 + 10 + k);
         tick();
      end
      chk("f_cnt4",  q_count, 4);
      chk("f_ready", slow_ready, 0);
      slow(1, 14, 32'h100 + 14);
      tick();
      chk("f_hold", q_count, 4);
      chk("f_ready_hold", slow_ready, 0);
      pipe(0, 0, 0);
      tick();
      chk("f_dst10",  WB_Dst, 10);
      chk("f_cnt3",   q_count, 3);
      chk("f_ready1", slow_ready, 1);
      tick();
      slow(0, 0, 0);
      chk("f_dst11",  WB_Dst, 11);
      chk("f_cnt3b",  q_count, 3);
      for (int k = 12; k <= 14; k++) begin
         tick();
         chk("f_drain_rfwr", RFWr, 1);
         chk("f_drain_dst",  WB_Dst, k);
         chk("f_drain_res",  WB_Result, 32'h100 + k);
      end
      chk("f_empty", q_count, 0);

      // queued r9 squashed by a younger pipe write
      pipe(1, 1, 32'h1);
      slow(1, 9, 32'h11);
      tick();
      slow(0, 0, 0);
      chk("s_cnt1", q_count, 1);
      pipe(1, 9, 32'h22);
      tick();
      pipe(0, 0, 0);
      chk("s_dst", WB_Dst, 9);
      chk("s_res", WB_Result, 32'h22);
      chk("s_cnt_keep", q_count, 1);
      ID_rt = 9;
      #1;
      chk("s_nostall", ID_Stall, 0);
      ID_rt = 0;
      tick();
      chk("s_dead_pop_rfwr", RFWr, 0);
      chk("s_dead_pop_cnt",  q_count, 0);

      // same-cycle slow and pipe to r4: slow beat enqueued dead
      pipe(1, 4, 32'h44);
      slow(1, 4, 32'h55);
      tick();
      pipe(0, 0, 0); slow(0, 0, 0);
      chk("sc_res", WB_Result, 32'h44);
      chk("sc_cnt", q_count, 1);
      tick();
      chk("sc_rfwr", RFWr, 0);
      chk("sc_cnt0", q_count, 0);

      // r0 destinations on both paths
      pipe(1, 0, 32'h99);
      slow(1, 0, 32'h98);
      #1;
      chk("z_ready", slow_ready, 1);
      tick();
      pipe(0, 0, 0); slow(0, 0, 0);
      chk("z_rfwr", RFWr, 0);
      chk("z_cnt",  q_count, 0);

      // asynchronous reset with three queued entries and the port busy
      for (int k = 0; k < 3; k++) begin
         pipe(1, 2, 32'h2);
         slow(1, 5'(20 + k), 32'h200 + k);
         tick();
      end
      chk("r_cnt3", q_count, 3);
      chk("r_rfwr1", RFWr, 1);
      pipe(0, 0, 0); slow(0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("r_async_rfwr", RFWr, 0);
      chk("r_async_cnt",  q_count, 0);
      chk("r_async_dst",  WB_Dst, 0);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("r_post_rfwr", RFWr, 0);
         chk("r_post_cnt",  q_count, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
